// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - instruction/data to single memory port arbiter; MEM_ARB_RR_EN selects round-robin
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instruction_valid,
    input  logic [ADDR_W-1:0] instruction_addr,
    output logic [31:0]       instruction_read,
    output logic              instruction_ready,
    input  logic              data_read_valid,
    input  logic              data_write_valid,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_write,
    input  logic [3:0]        data_write_byte,
    output logic [31:0]       data_read,
    output logic              data_ready,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, INSTR, DATA} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              data_req;
    logic              grant_data;
    logic              grant_instr;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              we_q;

    assign data_req = data_read_valid | data_write_valid;

`ifdef MEM_ARB_RR_EN
    // last_data: 1 when the data port was served last; reset leaves instruction as last served
    logic last_data;

    always_comb begin
        grant_data  = data_req && (!instruction_valid || !last_data);
        grant_instr = instruction_valid && !grant_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_data <= 1'b0;
        end else if (state == IDLE && (grant_data || grant_instr)) begin
            last_data <= grant_data;
        end
    end
`else
    always_comb begin
        grant_data  = data_req;
        grant_instr = instruction_valid && !data_req;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_data) begin
                    state_nxt = DATA;
                end else if (grant_instr) begin
                    state_nxt = INSTR;
                end
            end
            INSTR, DATA: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured at grant so requesters may change or drop them afterwards
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            we_q    <= 1'b0;
        end else if (state == IDLE) begin
            if (grant_data) begin
                addr_q  <= data_addr;
                wdata_q <= data_write;
                we_q    <= data_write_valid;
                wstrb_q <= data_write_valid ? data_write_byte : 4'b0000;
            end else if (grant_instr) begin
                addr_q  <= instruction_addr;
                we_q    <= 1'b0;
                wstrb_q <= 4'b0000;
            end
        end
    end

    assign mem_valid = (state == INSTR) || (state == DATA);
    assign mem_we    = (state == DATA) && we_q;
    assign mem_wstrb = mem_we ? wstrb_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign instruction_ready = (state == INSTR) && mem_ready;
    assign instruction_read  = mem_rdata;
    assign data_ready        = !data_req || ((state == DATA) && mem_ready);
    assign data_read         = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (default build, MEM_ARB_RR_EN aware)
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instruction_valid;
    logic [31:0] instruction_addr;
    logic [31:0] instruction_read;
    logic        instruction_ready;
    logic        data_read_valid;
    logic        data_write_valid;
    logic [31:0] data_addr;
    logic [31:0] data_write;
    logic [3:0]  data_write_byte;
    logic [31:0] data_read;
    logic        data_ready;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_d;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .instruction_valid (instruction_valid),
        .instruction_addr  (instruction_addr),
        .instruction_read  (instruction_read),
        .instruction_ready (instruction_ready),
        .data_read_valid   (data_read_valid),
        .data_write_valid  (data_write_valid),
        .data_addr         (data_addr),
        .data_write        (data_write),
        .data_write_byte   (data_write_byte),
        .data_read         (data_read),
        .data_ready        (data_ready),
        .mem_valid         (mem_valid),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_wstrb         (mem_wstrb),
        .mem_rdata         (mem_rdata),
        .mem_ready         (mem_ready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input logic [31:0] addr, input logic we,
                            input logic [3:0] strb, input logic [31:0] wdata);
        exp_t e;
        e.is_d = is_d; e.addr = addr; e.we = we; e.strb = strb; e.wdata = wdata;
        sb.push_back(e);
    endtask

    task automatic drop_all();
        instruction_valid = 1'b0;
        data_read_valid   = 1'b0;
        data_write_valid  = 1'b0;
    endtask

    // Called at a negedge; waits for the grant, checks the memory request against the
    // scoreboard head, inserts wait states, then completes with mem_ready.
    task automatic serve(input int waits, input logic [31:0] rd, input bit move_addr, input bit drop_early);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        while (!mem_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("grant", {31'd0, mem_valid}, 32'd1);
        check_eq("latency", n, 1);
        check_eq("mem_addr", mem_addr, e.addr);
        check_eq("mem_we", {31'd0, mem_we}, {31'd0, e.we});
        check_eq("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.strb});
        if (e.we) check_eq("mem_wdata", mem_wdata, e.wdata);
        if (move_addr) data_addr = 32'h3000;
        if (drop_early) drop_all();
        for (int i = 0; i < waits; i++) begin
            if (e.is_d) check_eq("d_busy", {31'd0, data_ready}, 32'd0);
            else        check_eq("i_busy", {31'd0, instruction_ready}, 32'd0);
            @(negedge clk);
            check_eq("addr_stable", mem_addr, e.addr);
            check_eq("valid_held", {31'd0, mem_valid}, 32'd1);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        #1;
        if (e.is_d) begin
            check_eq("d_ready", {31'd0, data_ready}, 32'd1);
            check_eq("d_read", data_read, rd);
            check_eq("i_quiet", {31'd0, instruction_ready}, 32'd0);
        end else begin
            check_eq("i_ready", {31'd0, instruction_ready}, 32'd1);
            check_eq("i_read", instruction_read, rd);
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = '0;
        check_eq("idle_gap", {31'd0, mem_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b0;
        drop_all();
        instruction_addr = '0;
        data_addr        = '0;
        data_write       = '0;
        data_write_byte  = '0;
        mem_rdata        = '0;
        mem_ready        = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("rst_we", {31'd0, mem_we}, 32'd0);
        check_eq("rst_strb", {28'd0, mem_wstrb}, 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_wdata", mem_wdata, 32'd0);
        check_eq("rst_irdy", {31'd0, instruction_ready}, 32'd0);
        check_eq("rst_drdy", {31'd0, data_ready}, 32'd1);
        reset = 1'b1;

        // stray mem_ready in IDLE
        @(negedge clk);
        mem_ready = 1'b1;
        #1 check_eq("idle_irdy", {31'd0, instruction_ready}, 32'd0);
        @(negedge clk);
        check_eq("idle_valid", {31'd0, mem_valid}, 32'd0);
        mem_ready = 1'b0;

        // fetch 0x100, two wait states
        @(negedge clk);
        instruction_valid = 1'b1; instruction_addr = 32'h100;
        push_exp(1'b0, 32'h100, 1'b0, 4'b0000, 32'h0);
        serve(2, 32'h0000_0013, 1'b0, 1'b0);
        drop_all();

        // store with data_addr moved during wait
        data_write_valid = 1'b1; data_addr = 32'h2000;
        data_write = 32'hDEAD_BEEF; data_write_byte = 4'b0011;
        push_exp(1'b1, 32'h2000, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        serve(3, 32'h0, 1'b1, 1'b0);
        drop_all();

        // load, zero wait states
        data_read_valid = 1'b1; data_addr = 32'h40;
        push_exp(1'b1, 32'h40, 1'b0, 4'b0000, 32'h0);
        serve(0, 32'hCAFE_F00D, 1'b0, 1'b0);
        drop_all();

        // read and write together -> write
        data_read_valid = 1'b1; data_write_valid = 1'b1; data_addr = 32'h80;
        data_write = 32'h1234_5678; data_write_byte = 4'b1100;
        push_exp(1'b1, 32'h80, 1'b1, 4'b1100, 32'h1234_5678);
        serve(1, 32'h0, 1'b0, 1'b0);
        drop_all();

        // fetch dropped after grant still completes
        instruction_valid = 1'b1; instruction_addr = 32'h204;
        push_exp(1'b0, 32'h204, 1'b0, 4'b0000, 32'h0);
        serve(2, 32'hA5A5_0001, 1'b0, 1'b1);
        drop_all();

        // contention: fetch and load both requested
        instruction_valid = 1'b1; instruction_addr = 32'h300;
        data_read_valid = 1'b1; data_addr = 32'h500;
`ifdef MEM_ARB_RR_EN
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) push_exp(1'b1, 32'h500, 1'b0, 4'b0000, 32'h0);
            else            push_exp(1'b0, 32'h300, 1'b0, 4'b0000, 32'h0);
            serve(1, 32'h100 + k, 1'b0, 1'b0);
        end
        drop_all();
`else
        push_exp(1'b1, 32'h500, 1'b0, 4'b0000, 32'h0);
        serve(1, 32'h1111_2222, 1'b0, 1'b0);
        data_read_valid = 1'b0;
        push_exp(1'b0, 32'h300, 1'b0, 4'b0000, 32'h0);
        serve(1, 32'h3333_4444, 1'b0, 1'b0);
        drop_all();
`endif

        // reset in the middle of a store
        @(negedge clk);
        data_write_valid = 1'b1; data_addr = 32'h2000;
        data_write = 32'hDEAD_BEEF; data_write_byte = 4'b1111;
        @(negedge clk);
        check_eq("pre_rst_valid", {31'd0, mem_valid}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("abort_we", {31'd0, mem_we}, 32'd0);
        check_eq("abort_addr", mem_addr, 32'd0);
        mem_ready = 1'b1;
        #1 check_eq("abort_drdy", {31'd0, data_ready}, 32'd0);
        @(negedge clk);
        mem_ready = 1'b0;
        drop_all();
        reset = 1'b1;
        @(negedge clk);
        check_eq("post_rst_valid", {31'd0, mem_valid}, 32'd0);
        check_eq("post_rst_drdy", {31'd0, data_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
